cacheline_mem_arbiter: RTL and testbench
========================================

Name: cacheline_mem_arbiter

Overview:
- Two-port arbiter sharing one line-wide memory port between the instruction cache (port I) and the data cache (port D).
- Each cache's downward-facing read/write/resp port connects to one requester port; the memory port connects to the line-granular memory model or burst adapter.
- One transaction is outstanding at a time. Requests are round-robin on tie, and the request is latched at grant.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_addr  in  ADDR_WIDTH  I-cache line address
- i_read  in  1  I-cache read request
- i_write  in  1  I-cache write request
- i_wdata  in  LINE_WIDTH  I-cache write line
- i_rdata  out  LINE_WIDTH  read line to I-cache
- i_resp  out  1  completion to I-cache
- i_raddr  out  ADDR_WIDTH  address tag of returned line to I-cache
- d_addr, d_read, d_write, d_wdata, d_rdata, d_resp, d_raddr: same as the I-port set, for the D-cache
- mem_addr  out  ADDR_WIDTH  memory request address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_wdata  out  LINE_WIDTH  memory write line
- mem_rdata  in  LINE_WIDTH  memory read line
- mem_resp  in  1  memory completion
- mem_raddr  in  ADDR_WIDTH  address of returned line

Behaviour:
- A requester asserts read or write and holds it until its resp. Read and write on the same port in the same cycle is illegal; the block asserts on it in simulation.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one port requesting: go to that port's GRANT state.
- IDLE, both ports requesting: grant the port not equal to last_grant.
- On every IDLE→GRANT transition, register the granted port's addr, read, write and wdata into req_q, and update last_grant.
- GRANT_x: drive mem_addr, mem_read, mem_write and mem_wdata from req_q.
  - Stay in GRANT_x until mem_resp=1.
  - On mem_resp, return to IDLE (mandatory one-cycle bubble, so the requester can deassert).
- Latency: request seen in cycle N → memory request valid in cycle N+1.
- In IDLE, mem_read=mem_write=0, and mem_addr/mem_wdata are don't-care.
- Response routing:
  - i_resp = mem_resp & (state==GRANT_I); d_resp = mem_resp & (state==GRANT_D).
  - i_rdata and d_rdata are both driven by mem_rdata (broadcast).
  - i_raddr = (state==GRANT_I) ? mem_raddr : 0; d_raddr likewise for GRANT_D.
- mem_resp in IDLE is ignored: no port resp is generated.
- A requester dropping its request while granted does not cancel the transaction. The latched request runs to completion.
- A new request arriving on the non-granted port waits, held by the requester, until the next IDLE.
- Reset, including mid-transaction:
  - state=IDLE, last_grant=I (so D wins the first tie).
  - req_q cleared to 0; all resp/read/write outputs 0; raddr outputs 0.
  - The memory side must tolerate an abandoned transaction.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, add outputs perf_i_grants (32), perf_d_grants (32) and perf_conflict_cycles (32).
  - The grant counters increment on each IDLE→GRANT_x transition for their port.
  - perf_conflict_cycles increments each cycle in which a requester is asserting but not granted. In IDLE with a single requester, nothing counts; with both requesting in IDLE, it counts 1.
  - All three counters saturate at 32'hFFFFFFFF and reset to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- I-only read:
  - Stimulus: i_read=1, i_addr=0x0000_1040; memory responds after 3 cycles with mem_rdata=pattern A, mem_raddr=0x1040.
  - Required response: mem_read asserted the cycle after the request with mem_addr=0x1040; i_resp=1 for exactly 1 cycle with i_rdata=A and i_raddr=0x1040; d_resp stays 0.
- Simultaneous I read and D write after reset:
  - Stimulus: d_addr=0x2000, d_wdata=B.
  - Required response: D granted first; mem_write=1 with mem_addr=0x2000, mem_wdata=B. After d_resp, one IDLE cycle, then I granted.
- Back-to-back contention, four rounds with both ports always requesting → grants alternate D, I, D, I; no port is granted twice in a row.
- Requester drops mid-grant:
  - Stimulus: d_read=1 with d_addr=0x3000, deasserted 1 cycle after grant.
  - Required response: mem_read stays 1 with mem_addr=0x3000 until mem_resp; d_resp pulses once.
- Spurious mem_resp=1 in IDLE → i_resp=d_resp=0 and no state change.
- Reset asserted during GRANT_I:
  - Required response: next cycle state=IDLE, mem_read=0, all resp outputs 0. A subsequent tie grants D.
  - With ARB_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter
//   Shares one line-wide memory port between the instruction cache (port I)
//   and the data cache (port D). One transaction is outstanding at a time.
//   On a tie in IDLE, the port that was not granted last time wins.
//   The request is captured into req_q on the grant edge and replayed to
//   memory until mem_resp. Every transaction ends with one IDLE bubble
//   cycle so the requester can drop its request.
//
//   Optional build macro: ARB_PERF_CNT_EN adds saturating performance
//   counters perf_i_grants, perf_d_grants and perf_conflict_cycles.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   i_addr/i_read/i_write/i_wdata   : I-cache request
//   i_rdata/i_resp/i_raddr          : I-cache completion
//   d_addr/d_read/d_write/d_wdata   : D-cache request
//   d_rdata/d_resp/d_raddr          : D-cache completion
//   mem_addr/mem_read/mem_write/mem_wdata : memory request
//   mem_rdata/mem_resp/mem_raddr          : memory completion
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | no transaction; arbitrate, latch the winner into req_q
// GRANT_I | I-port request from req_q in flight, wait for mem_resp
// GRANT_D | D-port request from req_q in flight, wait for mem_resp

module cacheline_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    output logic [ADDR_WIDTH-1:0] i_raddr,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] d_raddr,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    input  logic [ADDR_WIDTH-1:0] mem_raddr
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_i_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t                state;
    state_t                state_nxt;
    port_t                 last_grant;

    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  req_read_q;
    logic                  req_write_q;
    logic [LINE_WIDTH-1:0] req_wdata_q;

    logic                  i_req;
    logic                  d_req;
    logic                  grant_i;
    logic                  grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Single-cycle strobes marking the IDLE->GRANT edge.
    assign grant_i = (state == IDLE) && (state_nxt == GRANT_I);
    assign grant_d = (state == IDLE) && (state_nxt == GRANT_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT_I;
            req_addr_q  <= '0;
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                last_grant  <= PORT_I;
                req_addr_q  <= i_addr;
                req_read_q  <= i_read;
                req_write_q <= i_write;
                req_wdata_q <= i_wdata;
            end else if (grant_d) begin
                last_grant  <= PORT_D;
                req_addr_q  <= d_addr;
                req_read_q  <= d_read;
                req_write_q <= d_write;
                req_wdata_q <= d_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = req_addr_q;
        mem_wdata = req_wdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_raddr   = '0;
        d_raddr   = '0;

        case (state)
            IDLE: begin
                // mem_resp is ignored here: a late answer to a transaction
                // abandoned by reset must not complete anything.
                if (i_req && d_req) begin
                    state_nxt = (last_grant == PORT_I) ? GRANT_D : GRANT_I;
                end else if (i_req) begin
                    state_nxt = GRANT_I;
                end else if (d_req) begin
                    state_nxt = GRANT_D;
                end
            end
            GRANT_I: begin
                mem_read  = req_read_q;
                mem_write = req_write_q;
                i_resp    = mem_resp;
                i_raddr   = mem_raddr;
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                mem_read  = req_read_q;
                mem_write = req_write_q;
                d_resp    = mem_resp;
                d_raddr   = mem_raddr;
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data is broadcast; only the resp strobe says whose line it is.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

`ifdef ARB_PERF_CNT_EN
    logic conflict;

    // A port is waiting if it requests but is not the one being served.
    // In IDLE with both requesting exactly one of them loses the tie.
    always_comb begin
        conflict = 1'b0;
        case (state)
            IDLE:    conflict = i_req & d_req;
            GRANT_I: conflict = d_req;
            GRANT_D: conflict = i_req;
            default: conflict = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_grants        <= '0;
            perf_d_grants        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (grant_i && (perf_i_grants != 32'hFFFF_FFFF)) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (grant_d && (perf_d_grants != 32'hFFFF_FFFF)) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (conflict && (perf_conflict_cycles != 32'hFFFF_FFFF)) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_read && i_write))
                else $error("cacheline_mem_arbiter: i_read and i_write both set");
            assert (!(d_read && d_write))
                else $error("cacheline_mem_arbiter: d_read and d_write both set");
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
module tb_cacheline_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_addr, d_addr, mem_addr, mem_raddr;
    logic          i_read, i_write, d_read, d_write;
    logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_resp, d_resp;
    logic [AW-1:0] i_raddr, d_raddr;
    logic          mem_read, mem_write, mem_resp;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_i_grants, perf_d_grants, perf_conflict_cycles;
`endif

    int total = 0;
    int bad   = 0;

    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_b;

    cacheline_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .i_raddr   (i_raddr),
        .d_addr    (d_addr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .d_raddr   (d_raddr),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .mem_raddr (mem_raddr)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_addr = '0; i_read = 0; i_write = 0; i_wdata = '0;
        d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 0; mem_raddr = '0;
        tick();
        tick();
        mem_resp = 1'b1; mem_raddr = 32'h0000_0F00;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
        total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b%b want=00", i_resp, d_resp); end
        total++; if (i_raddr !== 32'h0 || d_raddr !== 32'h0) begin bad++; $display("FAIL reset_raddr got=%h/%h want=0/0", i_raddr, d_raddr); end
        mem_resp = 1'b0; mem_raddr = '0;
        rst = 1'b0;
    endtask

    task automatic test_i_read();
        i_addr = 32'h0000_1040; i_read = 1'b1;
        tick();
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL iread_mem_read got=%b want=1", mem_read); end
        total++; if (mem_addr !== 32'h0000_1040) begin bad++; $display("FAIL iread_mem_addr got=%h want=00001040", mem_addr); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL iread_mem_write got=%b want=0", mem_write); end
        tick();
        tick();
        total++; if (i_resp !== 1'b0 || mem_read !== 1'b1) begin bad++; $display("FAIL iread_wait got resp=%b read=%b want 0/1", i_resp, mem_read); end
        mem_rdata = pat_a; mem_raddr = 32'h0000_1040; mem_resp = 1'b1;
        #1;
        total++; if (i_resp !== 1'b1) begin bad++; $display("FAIL iread_resp got=%b want=1", i_resp); end
        total++; if (i_rdata !== pat_a) begin bad++; $display("FAIL iread_rdata got=%h want=%h", i_rdata, pat_a); end
        total++; if (i_raddr !== 32'h0000_1040) begin bad++; $display("FAIL iread_raddr got=%h want=00001040", i_raddr); end
        total++; if (d_resp !== 1'b0 || d_raddr !== 32'h0) begin bad++; $display("FAIL iread_d_quiet got resp=%b raddr=%h want 0/0", d_resp, d_raddr); end
        tick();
        i_read = 1'b0; mem_resp = 1'b0;
        #1;
        total++; if (i_resp !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL iread_bubble got resp=%b read=%b want 0/0", i_resp, mem_read); end
    endtask

    task automatic test_drop();
        d_addr = 32'h0000_3000; d_read = 1'b1;
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_3000) begin bad++; $display("FAIL drop_grant got read=%b addr=%h want 1/00003000", mem_read, mem_addr); end
        tick();
        d_read = 1'b0; d_addr = 32'h0000_FFC0;
        #1;
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_3000) begin bad++; $display("FAIL drop_hold1 got read=%b addr=%h want 1/00003000", mem_read, mem_addr); end
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_3000 || d_resp !== 1'b0) begin bad++; $display("FAIL drop_hold2 got read=%b addr=%h resp=%b want 1/00003000/0", mem_read, mem_addr, d_resp); end
        mem_resp = 1'b1; mem_raddr = 32'h0000_3000;
        #1;
        total++; if (d_resp !== 1'b1 || d_raddr !== 32'h0000_3000) begin bad++; $display("FAIL drop_resp got resp=%b raddr=%h want 1/00003000", d_resp, d_raddr); end
        tick();
        mem_resp = 1'b0;
        #1;
        total++; if (d_resp !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL drop_done got resp=%b read=%b want 0/0", d_resp, mem_read); end
        tick();
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL drop_no_regrant got read=%b want=0", mem_read); end
    endtask

    task automatic test_tie();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_addr = 32'h0000_5000; i_read = 1'b1;
        d_addr = 32'h0000_2000; d_wdata = pat_b; d_write = 1'b1;
        tick();
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL tie_d_first got write=%b read=%b want 1/0", mem_write, mem_read); end
        total++; if (mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL tie_d_addr got=%h want=00002000", mem_addr); end
        total++; if (mem_wdata !== pat_b) begin bad++; $display("FAIL tie_d_wdata got=%h want=%h", mem_wdata, pat_b); end
        mem_resp = 1'b1;
        #1;
        total++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin bad++; $display("FAIL tie_d_resp got d=%b i=%b want 1/0", d_resp, i_resp); end
        tick();
        d_write = 1'b0; mem_resp = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL tie_bubble got read=%b write=%b want 0/0", mem_read, mem_write); end
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_5000) begin bad++; $display("FAIL tie_i_second got read=%b addr=%h want 1/00005000", mem_read, mem_addr); end
        mem_resp = 1'b1;
        #1;
        total++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin bad++; $display("FAIL tie_i_resp got i=%b d=%b want 1/0", i_resp, d_resp); end
        tick();
        i_read = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_addr = 32'h0000_0100; i_read = 1'b1;
        d_addr = 32'h0000_0200; d_read = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp_addr = (r % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL b2b_idle round=%0d got read=%b want=0", r, mem_read); end
            tick();
            total++; if (mem_read !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("FAIL b2b_grant round=%0d got read=%b addr=%h want 1/%h", r, mem_read, mem_addr, exp_addr); end
            mem_resp = 1'b1;
            #1;
            total++;
            if ((r % 2 == 0 && (d_resp !== 1'b1 || i_resp !== 1'b0)) ||
                (r % 2 == 1 && (i_resp !== 1'b1 || d_resp !== 1'b0))) begin
                bad++; $display("FAIL b2b_resp round=%0d got i=%b d=%b", r, i_resp, d_resp);
            end
            tick();
            mem_resp = 1'b0;
            #1;
        end
`ifdef ARB_PERF_CNT_EN
        total++; if (perf_i_grants !== 32'd2 || perf_d_grants !== 32'd2) begin bad++; $display("FAIL perf_grants got i=%0d d=%0d want 2/2", perf_i_grants, perf_d_grants); end
        total++; if (perf_conflict_cycles !== 32'd8) begin bad++; $display("FAIL perf_conflict got=%0d want=8", perf_conflict_cycles); end
`endif
        i_read = 1'b0; d_read = 1'b0;
    endtask

    task automatic test_spurious();
        mem_resp = 1'b1; mem_raddr = 32'hDEAD_BEC0;
        #1;
        total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin bad++; $display("FAIL spur_resp got i=%b d=%b want 0/0", i_resp, d_resp); end
        total++; if (i_raddr !== 32'h0 || d_raddr !== 32'h0) begin bad++; $display("FAIL spur_raddr got %h/%h want 0/0", i_raddr, d_raddr); end
        tick();
        mem_resp = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL spur_state got read=%b write=%b want 0/0", mem_read, mem_write); end
        i_addr = 32'h0000_0040; i_read = 1'b1;
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_0040) begin bad++; $display("FAIL spur_after got read=%b addr=%h want 1/00000040", mem_read, mem_addr); end
        mem_resp = 1'b1;
        tick();
        i_read = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_addr = 32'h0000_7000; i_read = 1'b1;
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_7000) begin bad++; $display("FAIL rmid_grant got read=%b addr=%h want 1/00007000", mem_read, mem_addr); end
        rst = 1'b1; i_read = 1'b0;
        tick();
        mem_resp = 1'b1; mem_raddr = 32'h0000_7000;
        #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rmid_mem got read=%b write=%b want 0/0", mem_read, mem_write); end
        total++; if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_raddr !== 32'h0) begin bad++; $display("FAIL rmid_resp got i=%b d=%b raddr=%h want 0/0/0", i_resp, d_resp, i_raddr); end
`ifdef ARB_PERF_CNT_EN
        total++; if (perf_i_grants !== 32'd0 || perf_d_grants !== 32'd0 || perf_conflict_cycles !== 32'd0) begin bad++; $display("FAIL rmid_perf got %0d/%0d/%0d want 0/0/0", perf_i_grants, perf_d_grants, perf_conflict_cycles); end
`endif
        rst = 1'b0; mem_resp = 1'b0;
        i_addr = 32'h0000_7100; i_read = 1'b1;
        d_addr = 32'h0000_7200; d_read = 1'b1;
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_7200) begin bad++; $display("FAIL rmid_tie got read=%b addr=%h want 1/00007200", mem_read, mem_addr); end
        mem_resp = 1'b1;
        #1;
        total++; if (d_resp !== 1'b1) begin bad++; $display("FAIL rmid_d_resp got=%b want=1", d_resp); end
        tick();
        d_read = 1'b0; mem_resp = 1'b0;
        tick();
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_7100) begin bad++; $display("FAIL rmid_i_next got read=%b addr=%h want 1/00007100", mem_read, mem_addr); end
        mem_resp = 1'b1;
        #1;
        total++; if (i_resp !== 1'b1) begin bad++; $display("FAIL rmid_i_resp got=%b want=1", i_resp); end
        tick();
        i_read = 1'b0; mem_resp = 1'b0;
    endtask

    initial begin
        pat_a = {8{32'hA5A5_1040}};
        pat_b = {4{64'h0123_4567_89AB_2000}};
        test_reset();
        test_i_read();
        test_drop();
        test_tie();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
